// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot-image loader.
package uart_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned CSUM_W         = 8;
    localparam int unsigned LEN_BYTES      = 4;
    // Bytes of a length/word that are buffered before the final byte arrives
    localparam int unsigned PART_W         = BYTE_W * (BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Byte-in / memory-write-out bundle of the boot loader.
interface uart_loader_if
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_rst;

    // Loader side
    modport master (
        input  rx_byte, rx_valid,
        output mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst
    );

    // Byte source / memory / CPU side
    modport slave (
        output rx_byte, rx_valid,
        input  mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst
    );

endinterface

// File: rtl/uart_loader_byte_strobe.sv
// Rising-edge detector turning the uart_rx byte-valid level into a one-cycle strobe.
module byte_strobe (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_strobe_c
);

    logic r_level_q;

    // History resets high so a level already asserted at reset release is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_strobe_c = i_level & ~r_level_q;

endmodule

// File: rtl/uart_loader.sv
// Boot-image loader: parses length, packs little-endian words into memory,
// checks the trailing XOR checksum and releases the CPU on success.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned LEN_W     = BYTE_W * LEN_BYTES;
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;

    logic                w_strobe;
    logic [LEN_W-1:0]    w_len;
    logic [CNT_W-1:0]    w_wcnt_nxt;

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [PART_W-1:0]   r_len_lo;
    logic [PART_W-1:0]   r_word;
    logic [CNT_W-1:0]    r_nwords;
    logic [CNT_W-1:0]    r_wcnt;
    logic [CSUM_W-1:0]   r_csum;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_cpu_rst;

    byte_strobe u_strobe (
        .clk        (clk),
        .rst        (rst),
        .i_level    (bus.rx_valid),
        .o_strobe_c (w_strobe)
    );

    // Full length as it stands once the 4th length byte arrives
    assign w_len      = {bus.rx_byte, r_len_lo};
    assign w_wcnt_nxt = r_wcnt + CNT_W'(1);

    // Loader FSM with byte-lane packing, word counter and checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LEN;
            r_idx       <= 2'd0;
            r_len_lo    <= '0;
            r_word      <= '0;
            r_nwords    <= '0;
            r_wcnt      <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst   <= 1'b1;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_LEN: begin
                    if (w_strobe) begin
                        r_busy <= 1'b1;
                        r_idx  <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_len_lo[7:0]   <= bus.rx_byte;
                            2'd1: r_len_lo[15:8]  <= bus.rx_byte;
                            2'd2: r_len_lo[23:16] <= bus.rx_byte;
                            default: begin
                                r_nwords <= w_len[CNT_W-1:0];
                                if ({1'b0, w_len} > MAX_WORDS) begin
                                    r_state <= ST_ERR;
                                    r_error <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else if (w_len == '0) begin
                                    r_state <= ST_CSUM;
                                end else begin
                                    r_state <= ST_DATA;
                                end
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        r_csum <= r_csum ^ bus.rx_byte;
                        r_idx  <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_word[7:0]   <= bus.rx_byte;
                            2'd1: r_word[15:8]  <= bus.rx_byte;
                            2'd2: r_word[23:16] <= bus.rx_byte;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_wcnt[ADDR_W-1:0];
                                r_mem_wdata <= {bus.rx_byte, r_word};
                                r_wcnt      <= w_wcnt_nxt;
                                if (w_wcnt_nxt == r_nwords) begin
                                    r_state <= ST_CSUM;
                                end
                            end
                        endcase
                    end
                end
                ST_CSUM: begin
                    if (w_strobe) begin
                        r_busy <= 1'b0;
                        if (bus.rx_byte == r_csum) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE and ERR are terminal until reset
                end
            endcase
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.cpu_rst   = r_cpu_rst;

endmodule

// File: tb/tb_uart_loader.sv
// Directed testbench for uart_loader (ADDR_W = 4).
module tb_uart_loader;

    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   wr_n     = 0;
    logic [AW-1:0] wr_addr [0:255];
    logic [31:0]   wr_data [0:255];

    uart_loader_if #(.ADDR_W(AW)) bus ();

    uart_loader #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every write seen between clock edges
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr[wr_n % 256] = bus.mem_addr;
            wr_data[wr_n % 256] = bus.mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_nominal(input logic [7:0] cs);
        send_word(32'h0000_0002);
        send_word(32'h1200_FFAB);
        send_word(32'h1234_5678);
        send_byte(cs);
    endtask

    task automatic test_reset;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_rst} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_status got=%b exp=00001",
                     {bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_rst});
        end
        checks++;
        if (bus.mem_addr !== 4'h0) begin
            failures++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr);
        end
        checks++;
        if (bus.mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'h02);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL nom_busy_first got=%b exp=1", bus.busy);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h1200_FFAB);
        send_word(32'h1234_5678);
        checks++;
        if ({bus.done, bus.cpu_rst} !== 2'b01) begin
            failures++; $display("FAIL nom_pre_csum got=%b exp=01", {bus.done, bus.cpu_rst});
        end
        send_byte(8'h4E);
        checks++;
        if (wr_n - base !== 2) begin
            failures++; $display("FAIL nom_wr_count got=%0d exp=2", wr_n - base);
        end
        checks++;
        if ({wr_addr[base % 256], wr_data[base % 256]} !== {4'h0, 32'h1200_FFAB}) begin
            failures++;
            $display("FAIL nom_wr0 got=%h/%h exp=0/1200ffab", wr_addr[base % 256], wr_data[base % 256]);
        end
        checks++;
        if ({wr_addr[(base + 1) % 256], wr_data[(base + 1) % 256]} !== {4'h1, 32'h1234_5678}) begin
            failures++;
            $display("FAIL nom_wr1 got=%h/%h exp=1/12345678",
                     wr_addr[(base + 1) % 256], wr_data[(base + 1) % 256]);
        end
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.cpu_rst} !== 4'b0100) begin
            failures++;
            $display("FAIL nom_final got=%b exp=0100", {bus.busy, bus.done, bus.error, bus.cpu_rst});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {4'h1, 32'h1234_5678}) begin
            failures++; $display("FAIL nom_hold got=%h/%h exp=1/12345678", bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_bad_csum;
        int base;
        do_reset();
        base = wr_n;
        send_nominal(8'h4F);
        checks++;
        if (wr_n - base !== 2) begin
            failures++; $display("FAIL bad_wr_count got=%0d exp=2", wr_n - base);
        end
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.cpu_rst} !== 4'b0011) begin
            failures++;
            $display("FAIL bad_status got=%b exp=0011", {bus.busy, bus.done, bus.error, bus.cpu_rst});
        end
        send_word(32'hDEAD_BEEF);
        send_byte(8'h4E);
        checks++;
        if (wr_n - base !== 2) begin
            failures++; $display("FAIL bad_ignore_wr got=%0d exp=2", wr_n - base);
        end
        checks++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b011) begin
            failures++; $display("FAIL bad_sticky got=%b exp=011", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    task automatic test_empty;
        int base;
        do_reset();
        base = wr_n;
        send_word(32'h0);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            failures++; $display("FAIL empty_mid got=%b exp=10", {bus.busy, bus.done});
        end
        send_byte(8'h00);
        checks++;
        if (wr_n - base !== 0) begin
            failures++; $display("FAIL empty_wr got=%0d exp=0", wr_n - base);
        end
        checks++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            failures++; $display("FAIL empty_done got=%b exp=100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    task automatic test_overflow;
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'h11); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (bus.error !== 1'b0) begin
            failures++; $display("FAIL ovf_early got=%b exp=0", bus.error);
        end
        send_byte(8'h00);
        checks++;
        if ({bus.busy, bus.error, bus.cpu_rst} !== 3'b011) begin
            failures++; $display("FAIL ovf_17 got=%b exp=011", {bus.busy, bus.error, bus.cpu_rst});
        end
        send_word(32'h0403_0201);
        checks++;
        if (wr_n - base !== 0) begin
            failures++; $display("FAIL ovf_wr got=%0d exp=0", wr_n - base);
        end
        do_reset();
        send_word(32'h0100_0000);
        checks++;
        if (bus.error !== 1'b1) begin
            failures++; $display("FAIL ovf_high got=%b exp=1", bus.error);
        end
    endtask

    task automatic test_full;
        int          base;
        logic [7:0]  cs;
        logic [31:0] exp_w [0:15];
        do_reset();
        base = wr_n;
        cs   = 8'h00;
        send_word(32'd16);
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < 4; j++) begin
                exp_w[w][8*j +: 8] = 8'(((4 * w + j) * 3) + 1);
                cs = cs ^ exp_w[w][8*j +: 8];
            end
            send_word(exp_w[w]);
        end
        checks++;
        if ({bus.done, bus.error} !== 2'b00) begin
            failures++; $display("FAIL full_pre got=%b exp=00", {bus.done, bus.error});
        end
        send_byte(cs);
        checks++;
        if (wr_n - base !== 16) begin
            failures++; $display("FAIL full_wr_count got=%0d exp=16", wr_n - base);
        end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if ({wr_addr[(base + w) % 256], wr_data[(base + w) % 256]} !== {4'(w), exp_w[w]}) begin
                failures++;
                $display("FAIL full_wr%0d got=%h/%h exp=%h/%h", w, wr_addr[(base + w) % 256],
                         wr_data[(base + w) % 256], 4'(w), exp_w[w]);
            end
        end
        checks++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            failures++; $display("FAIL full_done got=%b exp=100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    task automatic test_level;
        int base;
        do_reset();
        @(negedge clk);
        bus.rx_byte  = 8'h01;
        bus.rx_valid = 1'b1;
        repeat (100) @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({bus.busy, bus.error} !== 2'b10) begin
            failures++; $display("FAIL lvl_held got=%b exp=10", {bus.busy, bus.error});
        end
        send_word(32'h4433_2211);
        send_byte(8'h44);
        checks++;
        if ({bus.done, bus.error} !== 2'b10) begin
            failures++; $display("FAIL lvl_held_done got=%b exp=10", {bus.done, bus.error});
        end
        // Level already high when reset is released
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_byte  = 8'h01;
        bus.rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL lvl_rst_release got=%b exp=0", bus.busy);
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        base = wr_n;
        send_word(32'h0000_0001);
        send_word(32'h4433_2211);
        send_byte(8'h44);
        checks++;
        if ({wr_n - base == 1, wr_data[base % 256], bus.done} !== {1'b1, 32'h4433_2211, 1'b1}) begin
            failures++;
            $display("FAIL lvl_rst_stream got=%0d/%h/%b exp=1/44332211/1",
                     wr_n - base, wr_data[base % 256], bus.done);
        end
    endtask

    task automatic test_reset_mid_word;
        int base;
        do_reset();
        send_word(32'h0000_0002);
        send_byte(8'hAB);
        send_byte(8'hFF);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_rst} !== 5'b00001) begin
            failures++;
            $display("FAIL mid_async got=%b exp=00001",
                     {bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_rst});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = wr_n;
        send_nominal(8'h4E);
        checks++;
        if (wr_n - base !== 2) begin
            failures++; $display("FAIL mid_wr_count got=%0d exp=2", wr_n - base);
        end
        checks++;
        if ({wr_data[base % 256], wr_data[(base + 1) % 256]} !== {32'h1200_FFAB, 32'h1234_5678}) begin
            failures++;
            $display("FAIL mid_wr_data got=%h/%h exp=1200ffab/12345678",
                     wr_data[base % 256], wr_data[(base + 1) % 256]);
        end
        checks++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            failures++; $display("FAIL mid_done got=%b exp=100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    initial begin
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_empty();
        test_overflow();
        test_full();
        test_level();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
